// File: rtl/reg_file_mp.sv
// Multi-ported register file: bypassed combinational reads, priority-resolved writes,
// per-register busy scoreboard for producer tracking, raw debug read port. r0 is hardwired zero.
module reg_file_mp #(
  parameter int DATA_WIDTH  = 32,
  parameter int REG_NUM_W   = 5,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [READ_PORTS*REG_NUM_W-1:0]   rd_num,
  output logic [READ_PORTS*DATA_WIDTH-1:0]  rd_data,
  output logic [READ_PORTS-1:0]             rd_busy,
  input  logic [WRITE_PORTS-1:0]            wr_en,
  input  logic [WRITE_PORTS*REG_NUM_W-1:0]  wr_num,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] wr_data,
  input  logic                              alloc_en,
  input  logic [REG_NUM_W-1:0]              alloc_num,
  input  logic [REG_NUM_W-1:0]              dbg_num,
  output logic [DATA_WIDTH-1:0]             dbg_data
);

  localparam int DEPTH = 1 << REG_NUM_W;

  logic [DATA_WIDTH-1:0] regMem [DEPTH];
  logic [DEPTH-1:0]      busyQ;

  // Per-register write resolution; ascending port loop lets the highest index win.
  // Gated by rst_n so nothing is bypassed or committed while reset is asserted.
  logic [DEPTH-1:0]      wrHit;
  logic [DATA_WIDTH-1:0] wrVal [DEPTH];

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      wrHit[k] = 1'b0;
      wrVal[k] = '0;
      if (k != 0) begin
        for (int p = 0; p < WRITE_PORTS; p++) begin
          if (rst_n && wr_en[p] && (wr_num[p*REG_NUM_W +: REG_NUM_W] == REG_NUM_W'(k))) begin
            wrHit[k] = 1'b1;
            wrVal[k] = wr_data[p*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        regMem[k] <= '0;
      end
      busyQ <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        if (wrHit[k]) begin
          regMem[k] <= wrVal[k];
        end
        // A new producer outranks the completion of the previous one.
        if (alloc_en && (alloc_num == REG_NUM_W'(k))) begin
          busyQ[k] <= 1'b1;
        end else if (wrHit[k]) begin
          busyQ[k] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < READ_PORTS; i++) begin
      logic [REG_NUM_W-1:0] rdIdx;
      rdIdx = rd_num[i*REG_NUM_W +: REG_NUM_W];
      if (rdIdx != '0) begin
        if (wrHit[rdIdx]) begin
          rd_data[i*DATA_WIDTH +: DATA_WIDTH] = wrVal[rdIdx];
        end else begin
          rd_data[i*DATA_WIDTH +: DATA_WIDTH] = regMem[rdIdx];
        end
        rd_busy[i] = busyQ[rdIdx] && !wrHit[rdIdx];
      end
    end
  end

  assign dbg_data = regMem[dbg_num];

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed testbench for reg_file_mp: cumulative per-cycle vector table plus
// hand-written reset sequences, checked through an expected-value queue.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int NW = 5;

  logic            clk;
  logic            rst_n;
  logic [2*NW-1:0] rd_num;
  logic [2*DW-1:0] rd_data;
  logic [1:0]      rd_busy;
  logic [1:0]      wr_en;
  logic [2*NW-1:0] wr_num;
  logic [2*DW-1:0] wr_data;
  logic            alloc_en;
  logic [NW-1:0]   alloc_num;
  logic [NW-1:0]   dbg_num;
  logic [DW-1:0]   dbg_data;

  reg_file_mp #(
    .DATA_WIDTH(DW), .REG_NUM_W(NW), .READ_PORTS(2), .WRITE_PORTS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_num(rd_num), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_num(alloc_num),
    .dbg_num(dbg_num), .dbg_data(dbg_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    wr_en;
    logic [NW-1:0] wr_num0;
    logic [DW-1:0] wr_data0;
    logic [NW-1:0] wr_num1;
    logic [DW-1:0] wr_data1;
    logic          alloc_en;
    logic [NW-1:0] alloc_num;
    logic [NW-1:0] rd_num0;
    logic [NW-1:0] rd_num1;
    logic [NW-1:0] dbg_num;
    logic [DW-1:0] exp_rd0;
    logic [DW-1:0] exp_rd1;
    logic [1:0]    exp_busy;
    logic [DW-1:0] exp_dbg;
  } vec_t;

  vec_t          vec_q[$];
  logic [DW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard: compare the three data outputs against queued expectations, then busy
  task automatic score(input string tag, input logic [1:0] exp_busy);
    logic [DW-1:0] e;
    if (exp_q.size() < 3) begin
      errors++;
      $display("FAIL %s: expected queue underflow", tag);
    end else begin
      e = exp_q.pop_front(); check({tag, " rd0"}, rd_data[DW-1:0], e);
      e = exp_q.pop_front(); check({tag, " rd1"}, rd_data[2*DW-1:DW], e);
      e = exp_q.pop_front(); check({tag, " dbg"}, dbg_data, e);
    end
    check({tag, " busy"}, {30'd0, rd_busy}, {30'd0, exp_busy});
  endtask

  // driver
  task automatic drive(input vec_t v);
    wr_en     = v.wr_en;
    wr_num    = {v.wr_num1, v.wr_num0};
    wr_data   = {v.wr_data1, v.wr_data0};
    alloc_en  = v.alloc_en;
    alloc_num = v.alloc_num;
    rd_num    = {v.rd_num1, v.rd_num0};
    dbg_num   = v.dbg_num;
  endtask

  task automatic add_vec(
    input logic [1:0] we, input logic [NW-1:0] n0, input logic [DW-1:0] d0,
    input logic [NW-1:0] n1, input logic [DW-1:0] d1,
    input logic ae, input logic [NW-1:0] an,
    input logic [NW-1:0] r0, input logic [NW-1:0] r1, input logic [NW-1:0] dn,
    input logic [DW-1:0] e0, input logic [DW-1:0] e1, input logic [1:0] eb,
    input logic [DW-1:0] ed);
    vec_t v;
    v = '{we, n0, d0, n1, d1, ae, an, r0, r1, dn, e0, e1, eb, ed};
    vec_q.push_back(v);
  endtask

  task automatic idle_vec(output vec_t v);
    v = '0;
  endtask

  initial begin
    vec_t v;

    //       we     n0  d0            n1  d1            ae  an  r0  r1  dbg  exp0          exp1          busy   expdbg
    add_vec(2'b00, 0, 0,            0, 0,            0, 0,  0,  0,  0,  0,            0,            2'b00, 0);
    add_vec(2'b01, 3, 32'hAA,       0, 0,            0, 0,  3,  3,  3,  32'hAA,       32'hAA,       2'b00, 0);
    add_vec(2'b00, 0, 0,            0, 0,            0, 0,  3,  0,  3,  32'hAA,       0,            2'b00, 32'hAA);
    add_vec(2'b11, 7, 32'h11,       7, 32'h22,       0, 0,  7,  7,  7,  32'h22,       32'h22,       2'b00, 0);
    add_vec(2'b00, 0, 0,            0, 0,            0, 0,  7,  3,  7,  32'h22,       32'hAA,       2'b00, 32'h22);
    add_vec(2'b01, 0, 32'hFFFFFFFF, 0, 0,            0, 0,  0,  7,  0,  0,            32'h22,       2'b00, 0);
    add_vec(2'b00, 0, 0,            0, 0,            0, 0,  0,  0,  0,  0,            0,            2'b00, 0);
    add_vec(2'b00, 0, 0,            0, 0,            1, 4,  4,  0,  4,  0,            0,            2'b00, 0);
    add_vec(2'b00, 0, 0,            0, 0,            0, 0,  4,  4,  4,  0,            0,            2'b11, 0);
    add_vec(2'b00, 0, 0,            0, 0,            0, 0,  4,  3,  0,  0,            32'hAA,       2'b01, 0);
    add_vec(2'b10, 0, 0,            4, 32'h55,       0, 0,  4,  3,  4,  32'h55,       32'hAA,       2'b00, 0);
    add_vec(2'b00, 0, 0,            0, 0,            0, 0,  4,  4,  4,  32'h55,       32'h55,       2'b00, 32'h55);
    add_vec(2'b01, 9, 32'h66,       0, 0,            1, 9,  9,  0,  9,  32'h66,       0,            2'b00, 0);
    add_vec(2'b00, 0, 0,            0, 0,            0, 0,  9,  0,  9,  32'h66,       0,            2'b01, 32'h66);
    add_vec(2'b00, 0, 0,            0, 0,            1, 9,  9,  9,  9,  32'h66,       32'h66,       2'b11, 32'h66);
    add_vec(2'b11, 5, 32'h1234,     6, 32'h5678,     0, 0,  5,  6,  5,  32'h1234,     32'h5678,     2'b00, 0);
    add_vec(2'b00, 0, 0,            0, 0,            0, 0,  5,  9,  6,  32'h1234,     32'h66,       2'b10, 32'h5678);
    add_vec(2'b00, 0, 0,            0, 0,            1, 0,  0,  9,  0,  0,            32'h66,       2'b10, 0);
    add_vec(2'b00, 0, 0,            0, 0,            0, 0,  0,  0,  0,  0,            0,            2'b00, 0);

    // power-on reset
    idle_vec(v);
    drive(v);
    rst_n = 1'b0;
    #1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    score("por", 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vec_q[i]) begin
      @(negedge clk);
      drive(vec_q[i]);
      #1;
      exp_q.push_back(vec_q[i].exp_rd0);
      exp_q.push_back(vec_q[i].exp_rd1);
      exp_q.push_back(vec_q[i].exp_dbg);
      score($sformatf("vec%0d", i), vec_q[i].exp_busy);
    end

    // mid-operation reset: r5=0x1234 and busy r9 are live; a write+alloc pending in reset is lost
    @(negedge clk);
    idle_vec(v);
    v.rd_num0 = 5; v.rd_num1 = 9; v.dbg_num = 5;
    v.wr_en = 2'b01; v.wr_num0 = 5; v.wr_data0 = 32'hBEEF;
    v.alloc_en = 1'b1; v.alloc_num = 5;
    drive(v);
    rst_n = 1'b0;
    #1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    score("rst_hold", 2'b00);

    @(negedge clk);
    idle_vec(v);
    v.rd_num0 = 5; v.rd_num1 = 9; v.dbg_num = 9;
    drive(v);
    #1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    score("rst_in_edge", 2'b00);
    rst_n = 1'b1;
    #1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    score("rst_release", 2'b00);

    @(negedge clk);
    idle_vec(v);
    v.rd_num0 = 5; v.rd_num1 = 3; v.dbg_num = 7;
    drive(v);
    #1;
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    score("post_rst", 2'b00);

    // write after reset works again
    @(negedge clk);
    idle_vec(v);
    v.wr_en = 2'b10; v.wr_num1 = 5; v.wr_data1 = 32'hCAFE;
    v.rd_num0 = 5; v.dbg_num = 5;
    drive(v);
    #1;
    exp_q.push_back(32'hCAFE); exp_q.push_back(0); exp_q.push_back(0);
    score("post_rst_wr", 2'b00);
    @(negedge clk);
    idle_vec(v);
    v.rd_num0 = 5; v.rd_num1 = 5; v.dbg_num = 5;
    drive(v);
    #1;
    exp_q.push_back(32'hCAFE); exp_q.push_back(32'hCAFE); exp_q.push_back(32'hCAFE);
    score("post_rst_rd", 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
